writeback_unit: RTL and testbench
=================================

// Module: writeback_unit
// PURPOSE
//  Final stage of the mycpu datapath: the producer side of the register-file write port consumed by decode.
//  Accepts retiring instructions from the memory stage via valid/ready.
//  Waits for variable-latency data-memory load responses, aligns and extends load data per MemOP, and
//  selects ALU vs load result by MemtoReg. Drives the single registered WB->DEC write port and counts
//  retired instructions.
// PARAMETERS
//  LOAD_TIMEOUT  16  cycles allowed in WAIT_LOAD before abort (>=1)
//  CNT_W         32  width of instret counter
// PORTS
//  clk                      in   1   clock, all state on rising edge
//  rst                      in   1   asynchronous, active-high reset
//  mem_valid_i              in   1   memory stage presents a retiring instruction
//  mem_ready_o              out  1   unit can accept (combinational: state==IDLE)
//  mem_reg_wr_i             in   1   instruction writes rd (RegWr)
//  mem_rd_id_i              in   5   destination register id
//  mem_to_reg_i             in   1   1 = result from load data, 0 = alu_result_i
//  mem_op_i                 in   3   load type: 000 LB,001 LH,010 LW,100 LBU,101 LHU
//  mem_addr_lo_i            in   2   byte address bits [1:0] of load
//  alu_result_i             in   32  ALU / immediate result
//  dmem_rvalid_i            in   1   data-memory read response valid (one-cycle pulse)
//  dmem_rdata_i             in   32  raw aligned word from data memory
//  WBtoDEC_REG_WRITE_EN_OUT out  1   register write strobe to decode
//  WBtoDEC_REG_ID_OUT       out  5   register id to decode
//  WBtoDEC_DATA_OUT         out  32  write data to decode
//  instret_o                out  CNT_W retired-instruction count
//  load_err_o               out  1   sticky: a load timed out
// BEHAVIOUR
//  Reset (async): state=IDLE; WRITE_EN=0, REG_ID=0, DATA=0, instret_o=0, load_err_o=0, timer=0.
//  Handshake: accept when mem_valid_i & mem_ready_o at posedge; inputs sampled only then.
//  FSM IDLE: accept with mem_to_reg_i=0 -> stay IDLE; accept with mem_to_reg_i=1 -> WAIT_LOAD,
//    latch rd_id, reg_wr, mem_op, addr_lo; timer=0.
//  FSM WAIT_LOAD: mem_ready_o=0. dmem_rvalid_i=1 -> write (see below), ->IDLE.
//    timer==LOAD_TIMEOUT-1 without rvalid -> load_err_o=1, no write, no instret increment, ->IDLE.
//    rvalid on the timeout cycle wins (normal completion).
//  dmem_rvalid_i in IDLE is ignored (no write, no error).
//  Latency: ALU accept in cycle N -> WRITE_EN high in N+1; load rvalid in cycle M -> WRITE_EN high in M+1.
//  WRITE_EN is a one-cycle pulse per retired instruction; REG_ID/DATA hold last value otherwise.
//  WRITE_EN = reg_wr & (rd_id!=0); x0 writes suppressed but instruction still counts as retired.
//  Load alignment: byte = rdata[8*addr_lo +: 8]; half = addr_lo[1] ? rdata[31:16] : rdata[15:0]
//    (addr_lo[0] ignored for halves). LB/LH sign-extend, LBU/LHU zero-extend, LW raw word.
//    Undefined mem_op (011,110,111) -> raw word.
//  instret_o += 1 on each completed retirement (ALU accept or load completion); wraps modulo 2^CNT_W.
//  Back-to-back ALU accepts every cycle sustain one write per cycle.
//  Reset mid-WAIT_LOAD: pending load discarded, no write issued afterwards.
// TESTING
//  ALU: accept rd=5, alu=0x1234_5678, reg_wr=1 -> next cycle EN=1, ID=5, DATA=0x12345678, instret=1.
//  LB: addr_lo=3, rvalid 3 cycles later with rdata=0x80FF_0000 -> DATA=0xFFFF_FF80, ready low until
//    completion; LBU same -> 0x0000_0080.
//  LH addr_lo=2, rdata=0x8001_7FFF -> 0xFFFF_8001; LHU addr_lo=0 -> 0x0000_7FFF; LW -> raw.
//  rd=0 with reg_wr=1 -> EN stays 0, instret increments; reg_wr=0 -> EN 0.
//  Load with no rvalid for 16 cycles -> load_err_o=1, no EN pulse, ready returns; late rvalid ignored.
//  Assert rst during WAIT_LOAD, then rvalid -> outputs all 0, no write; 4 back-to-back ALU ops -> 4
//    consecutive EN pulses, instret=4.

Source files
------------

// File: rtl/writeback_unit.sv
// Writeback stage: retires ALU results or aligned/extended load data onto the single registered
// register-file write port toward decode, and counts retired instructions.
module writeback_unit #(
  parameter int LOAD_TIMEOUT = 16,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid_i,
  output logic             mem_ready_o,
  input  logic             mem_reg_wr_i,
  input  logic [4:0]       mem_rd_id_i,
  input  logic             mem_to_reg_i,
  input  logic [2:0]       mem_op_i,
  input  logic [1:0]       mem_addr_lo_i,
  input  logic [31:0]      alu_result_i,
  input  logic             dmem_rvalid_i,
  input  logic [31:0]      dmem_rdata_i,
  output logic             WBtoDEC_REG_WRITE_EN_OUT,
  output logic [4:0]       WBtoDEC_REG_ID_OUT,
  output logic [31:0]      WBtoDEC_DATA_OUT,
  output logic [CNT_W-1:0] instret_o,
  output logic             load_err_o
);

  localparam int TW = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(LOAD_TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [4:0]        rd_id_q, rd_id_d;
  logic              reg_wr_q, reg_wr_d;
  logic [2:0]        mem_op_q, mem_op_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic              wen_q, wen_d;
  logic [4:0]        wid_q, wid_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic              err_q, err_d;
  logic              accept;

  function automatic logic [31:0] load_align(input logic [2:0]  op,
                                             input logic [1:0]  addr,
                                             input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{addr, 3'b000} +: 8];
    h = addr[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return rdata;
    endcase
  endfunction

  assign mem_ready_o = (state_q == IDLE);
  assign accept      = mem_valid_i & mem_ready_o;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    rd_id_d   = rd_id_q;
    reg_wr_d  = reg_wr_q;
    mem_op_d  = mem_op_q;
    addr_lo_d = addr_lo_q;
    wen_d     = 1'b0;
    wid_d     = wid_q;
    wdata_d   = wdata_q;
    instret_d = instret_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (mem_to_reg_i) begin
            state_d   = WAIT_LOAD;
            timer_d   = '0;
            rd_id_d   = mem_rd_id_i;
            reg_wr_d  = mem_reg_wr_i;
            mem_op_d  = mem_op_i;
            addr_lo_d = mem_addr_lo_i;
          end else begin
            wen_d     = mem_reg_wr_i & (mem_rd_id_i != 5'd0);
            instret_d = instret_q + CNT_W'(1);
            if (wen_d) begin
              wid_d   = mem_rd_id_i;
              wdata_d = alu_result_i;
            end
          end
        end
      end
      WAIT_LOAD: begin
        // a response arriving on the last allowed cycle still completes normally
        if (dmem_rvalid_i) begin
          state_d   = IDLE;
          wen_d     = reg_wr_q & (rd_id_q != 5'd0);
          instret_d = instret_q + CNT_W'(1);
          if (wen_d) begin
            wid_d   = rd_id_q;
            wdata_d = load_align(mem_op_q, addr_lo_q, dmem_rdata_i);
          end
        end else if (timer_q == TIMER_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      rd_id_q   <= '0;
      reg_wr_q  <= 1'b0;
      mem_op_q  <= '0;
      addr_lo_q <= '0;
      wen_q     <= 1'b0;
      wid_q     <= '0;
      wdata_q   <= '0;
      instret_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      rd_id_q   <= rd_id_d;
      reg_wr_q  <= reg_wr_d;
      mem_op_q  <= mem_op_d;
      addr_lo_q <= addr_lo_d;
      wen_q     <= wen_d;
      wid_q     <= wid_d;
      wdata_q   <= wdata_d;
      instret_q <= instret_d;
      err_q     <= err_d;
    end
  end

  assign WBtoDEC_REG_WRITE_EN_OUT = wen_q;
  assign WBtoDEC_REG_ID_OUT       = wid_q;
  assign WBtoDEC_DATA_OUT         = wdata_q;
  assign instret_o                = instret_q;
  assign load_err_o               = err_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed vector table, randomized ops against a reference model,
// and hand-written sequences for timeout, reset during a pending load and back-to-back retirement.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid_i = 1'b0;
  logic        mem_ready_o;
  logic        mem_reg_wr_i = 1'b0;
  logic [4:0]  mem_rd_id_i = '0;
  logic        mem_to_reg_i = 1'b0;
  logic [2:0]  mem_op_i = '0;
  logic [1:0]  mem_addr_lo_i = '0;
  logic [31:0] alu_result_i = '0;
  logic        dmem_rvalid_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;
  logic        WBtoDEC_REG_WRITE_EN_OUT;
  logic [4:0]  WBtoDEC_REG_ID_OUT;
  logic [31:0] WBtoDEC_DATA_OUT;
  logic [31:0] instret_o;
  logic        load_err_o;

  writeback_unit #(.LOAD_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o),
    .mem_reg_wr_i(mem_reg_wr_i), .mem_rd_id_i(mem_rd_id_i),
    .mem_to_reg_i(mem_to_reg_i), .mem_op_i(mem_op_i),
    .mem_addr_lo_i(mem_addr_lo_i), .alu_result_i(alu_result_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .WBtoDEC_REG_WRITE_EN_OUT(WBtoDEC_REG_WRITE_EN_OUT),
    .WBtoDEC_REG_ID_OUT(WBtoDEC_REG_ID_OUT),
    .WBtoDEC_DATA_OUT(WBtoDEC_DATA_OUT),
    .instret_o(instret_o), .load_err_o(load_err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic        exp_en;
  logic [4:0]  exp_id;
  logic [31:0] exp_data;
  logic [31:0] exp_instret;
  logic        exp_err;

  typedef struct {
    logic        is_load;
    logic        reg_wr;
    logic [4:0]  rd;
    logic [2:0]  op;
    logic [1:0]  addr;
    logic [31:0] alu;
    logic [31:0] rdata;
    int          delay;
    logic        exp_en;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] addr,
                                           input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * addr)) & 32'hFF;
    h = (addr >= 2'd2) ? (w >> 16) : (w & 32'hFFFF);
    case (op)
      3'b000:  return (b >= 32'd128) ? b - 32'd256 : b;
      3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  task automatic model_reset();
    exp_en = 0; exp_id = 0; exp_data = 0; exp_instret = 0; exp_err = 0;
  endtask

  task automatic model_retire(input logic timed_out, input logic en, input logic [4:0] rd,
                              input logic [31:0] data);
    exp_en = 1'b0;
    if (timed_out) exp_err = 1'b1;
    else begin
      exp_instret = exp_instret + 1;
      exp_en = en;
      if (en) begin
        exp_id = rd;
        exp_data = data;
      end
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".en"}, WBtoDEC_REG_WRITE_EN_OUT, exp_en);
    chk({tag, ".id"}, WBtoDEC_REG_ID_OUT, exp_id);
    chk({tag, ".data"}, WBtoDEC_DATA_OUT, exp_data);
    chk({tag, ".instret"}, instret_o, exp_instret);
    chk({tag, ".err"}, load_err_o, exp_err);
    chk({tag, ".ready"}, mem_ready_o, 1'b1);
  endtask

  // delay: cycles from accept to the rvalid pulse (1..16); 0 = never respond
  task automatic run_op(input logic is_load, input logic reg_wr, input logic [4:0] rd,
                        input logic [2:0] op, input logic [1:0] addr, input logic [31:0] alu,
                        input logic [31:0] rdata, input int delay);
    @(negedge clk);
    chk("en_one_cycle", WBtoDEC_REG_WRITE_EN_OUT, 1'b0);
    mem_valid_i = 1'b1; mem_reg_wr_i = reg_wr; mem_rd_id_i = rd; mem_to_reg_i = is_load;
    mem_op_i = op; mem_addr_lo_i = addr; alu_result_i = alu;
    @(negedge clk);
    mem_valid_i = 1'b0;
    mem_reg_wr_i = ~reg_wr; mem_rd_id_i = ~rd; mem_op_i = ~op; mem_addr_lo_i = ~addr;
    alu_result_i = ~alu;
    if (is_load) begin
      if (delay > 0) begin
        for (int c = 1; c < delay; c++) begin
          chk("wait_ready_low", mem_ready_o, 1'b0);
          chk("wait_no_en", WBtoDEC_REG_WRITE_EN_OUT, 1'b0);
          @(negedge clk);
        end
        chk("wait_ready_low", mem_ready_o, 1'b0);
        dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata;
        @(negedge clk);
        dmem_rvalid_i = 1'b0; dmem_rdata_i = $urandom;
      end else begin
        for (int c = 1; c <= 16; c++) begin
          chk("to_ready_low", mem_ready_o, 1'b0);
          chk("to_err_low", load_err_o, exp_err);
          @(negedge clk);
        end
        chk("to_no_en", WBtoDEC_REG_WRITE_EN_OUT, 1'b0);
        // late response lands in IDLE and must be ignored
        dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata;
        @(negedge clk);
        dmem_rvalid_i = 1'b0;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 5'd5,  3'b000, 2'd0, 32'h1234_5678, 32'h0,         0,  1'b1, 32'h1234_5678};
    vecs[1]  = '{1'b1, 1'b1, 5'd6,  3'b000, 2'd3, 32'h0,         32'h80FF_0000, 3,  1'b1, 32'hFFFF_FF80};
    vecs[2]  = '{1'b1, 1'b1, 5'd7,  3'b100, 2'd3, 32'h0,         32'h80FF_0000, 3,  1'b1, 32'h0000_0080};
    vecs[3]  = '{1'b1, 1'b1, 5'd8,  3'b001, 2'd2, 32'h0,         32'h8001_7FFF, 2,  1'b1, 32'hFFFF_8001};
    vecs[4]  = '{1'b1, 1'b1, 5'd9,  3'b101, 2'd0, 32'h0,         32'h8001_7FFF, 1,  1'b1, 32'h0000_7FFF};
    vecs[5]  = '{1'b1, 1'b1, 5'd10, 3'b010, 2'd0, 32'h0,         32'h8001_7FFF, 4,  1'b1, 32'h8001_7FFF};
    vecs[6]  = '{1'b0, 1'b1, 5'd0,  3'b000, 2'd0, 32'hAAAA_5555, 32'h0,         0,  1'b0, 32'h0};
    vecs[7]  = '{1'b0, 1'b0, 5'd7,  3'b000, 2'd0, 32'h5555_AAAA, 32'h0,         0,  1'b0, 32'h0};
    vecs[8]  = '{1'b1, 1'b1, 5'd11, 3'b001, 2'd3, 32'h0,         32'h8001_7FFF, 2,  1'b1, 32'hFFFF_8001};
    vecs[9]  = '{1'b1, 1'b1, 5'd12, 3'b011, 2'd1, 32'h0,         32'hDEAD_BEEF, 2,  1'b1, 32'hDEAD_BEEF};
    vecs[10] = '{1'b1, 1'b1, 5'd13, 3'b000, 2'd1, 32'h0,         32'h0000_7F00, 5,  1'b1, 32'h0000_007F};
    vecs[11] = '{1'b1, 1'b1, 5'd14, 3'b010, 2'd2, 32'h0,         32'h0BAD_F00D, 16, 1'b1, 32'h0BAD_F00D};
    vecs[12] = '{1'b1, 1'b1, 5'd0,  3'b010, 2'd0, 32'h0,         32'h1111_2222, 1,  1'b0, 32'h0};

    model_reset();
    repeat (2) @(negedge clk);
    check_state("reset");
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].is_load, vecs[i].reg_wr, vecs[i].rd, vecs[i].op, vecs[i].addr,
             vecs[i].alu, vecs[i].rdata, vecs[i].delay);
      model_retire(1'b0, vecs[i].exp_en, vecs[i].rd, vecs[i].exp_data);
      check_state($sformatf("vec%0d", i));
    end

    for (int n = 0; n < 60; n++) begin
      logic        ld, rw;
      logic [4:0]  rd;
      logic [2:0]  op;
      logic [1:0]  ad;
      logic [31:0] alu, rdat;
      int          dly;
      ld   = ($urandom_range(0, 1) == 1);
      rw   = ($urandom_range(0, 4) != 0);
      rd   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      op   = 3'($urandom_range(0, 7));
      ad   = 2'($urandom_range(0, 3));
      alu  = $urandom;
      rdat = $urandom;
      dly  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 16);
      run_op(ld, rw, rd, op, ad, alu, rdat, ld ? dly : 0);
      if (ld && dly == 0) model_retire(1'b1, 1'b0, rd, 32'h0);
      else model_retire(1'b0, rw && (rd != 0), rd, ld ? ref_load(op, ad, rdat) : alu);
      check_state($sformatf("rnd%0d", n));
    end

    // explicit timeout with late response
    run_op(1'b1, 1'b1, 5'd3, 3'b010, 2'd0, 32'h0, 32'hCAFE_F00D, 0);
    model_retire(1'b1, 1'b0, 5'd3, 32'h0);
    check_state("timeout");
    chk("timeout.err_set", load_err_o, 1'b1);

    // reset while a load is pending, then a stray response
    @(negedge clk);
    mem_valid_i = 1'b1; mem_to_reg_i = 1'b1; mem_reg_wr_i = 1'b1; mem_rd_id_i = 5'd4;
    mem_op_i = 3'b010;
    @(negedge clk);
    mem_valid_i = 1'b0;
    chk("rstmid.pending", mem_ready_o, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_state("rstmid.in_reset");
    @(negedge clk);
    rst = 1'b0;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h7777_7777;
    @(negedge clk);
    dmem_rvalid_i = 1'b0;
    check_state("rstmid.after_rvalid");
    @(negedge clk);
    check_state("rstmid.later");

    // four back-to-back ALU retirements
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        model_retire(1'b0, 1'b1, 5'(i), 32'h100 + 32'(i));
        check_state($sformatf("b2b%0d", i));
      end
      mem_valid_i = 1'b1; mem_to_reg_i = 1'b0; mem_reg_wr_i = 1'b1;
      mem_rd_id_i = 5'(i + 1); alu_result_i = 32'h100 + 32'(i + 1);
    end
    @(negedge clk);
    mem_valid_i = 1'b0;
    model_retire(1'b0, 1'b1, 5'd4, 32'h104);
    check_state("b2b4");
    @(negedge clk);
    exp_en = 1'b0;
    check_state("b2b_end");
    chk("b2b.instret", instret_o, 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
